// File: rtl/alu.sv
// Registered 16-operation integer ALU with one-cycle latency and a valid strobe.
// Define ALU_FLAGS_EN to add the registered Zero and DivZero outputs.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
`ifdef ALU_FLAGS_EN
  output logic             Zero,
  output logic             DivZero,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] op_result;

  logic [WIDTH-1:0] alu_out_d, alu_out_q;
  logic             carry_d, carry_q;
  logic             out_valid_d, out_valid_q;
`ifdef ALU_FLAGS_EN
  logic             zero_d, zero_q;
  logic             div_zero_d, div_zero_q;
`endif

  always_comb begin
    sum_full  = {1'b0, A} + {1'b0, B};
    op_result = '0;
    case (ALU_Sel)
      4'h0: op_result = sum_full[WIDTH-1:0];
      4'h1: op_result = A - B;
      4'h2: op_result = A * B;
      // Divide by zero saturates to all ones instead of the simulator's X/0.
      4'h3: op_result = (B == '0) ? '1 : (A / B);
      4'h4: op_result = {A[WIDTH-2:0], 1'b0};
      4'h5: op_result = {1'b0, A[WIDTH-1:1]};
      4'h6: op_result = {A[WIDTH-2:0], A[WIDTH-1]};
      4'h7: op_result = {A[0], A[WIDTH-1:1]};
      4'h8: op_result = A & B;
      4'h9: op_result = A | B;
      4'hA: op_result = A ^ B;
      4'hB: op_result = ~(A | B);
      4'hC: op_result = ~(A & B);
      4'hD: op_result = ~(A ^ B);
      4'hE: op_result = {{(WIDTH-1){1'b0}}, (A > B)};
      4'hF: op_result = {{(WIDTH-1){1'b0}}, (A == B)};
      default: op_result = '0;
    endcase
  end

  always_comb begin
    alu_out_d   = alu_out_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
`ifdef ALU_FLAGS_EN
    zero_d      = zero_q;
    div_zero_d  = div_zero_q;
`endif
    if (in_valid) begin
      alu_out_d = op_result;
      carry_d   = sum_full[WIDTH];
`ifdef ALU_FLAGS_EN
      zero_d     = (op_result == '0);
      div_zero_d = (ALU_Sel == 4'h3) && (B == '0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q      <= 1'b0;
      div_zero_q  <= 1'b0;
`endif
    end else begin
      alu_out_q   <= alu_out_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_FLAGS_EN
      zero_q      <= zero_d;
      div_zero_q  <= div_zero_d;
`endif
    end
  end

  assign ALU_Out   = alu_out_q;
  assign CarryOut  = carry_q;
  assign out_valid = out_valid_q;
`ifdef ALU_FLAGS_EN
  assign Zero      = zero_q;
  assign DivZero   = div_zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: expected results are queued when an op is driven
// and popped when out_valid is observed. Checks Zero/DivZero when ALU_FLAGS_EN is defined.
module tb_alu;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A, B;
  logic [3:0]       ALU_Sel;
  logic             in_valid;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;
  logic             out_valid;
`ifdef ALU_FLAGS_EN
  logic             Zero, DivZero;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       divz;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       carry;
  } vec_t;

  exp_t exp_q[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  alu #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .ALU_Sel(ALU_Sel),
    .in_valid(in_valid),
    .ALU_Out(ALU_Out),
    .CarryOut(CarryOut),
`ifdef ALU_FLAGS_EN
    .Zero(Zero),
    .DivZero(DivZero),
`endif
    .out_valid(out_valid)
  );

  // Independent reference model used for the randomised traffic.
  function automatic exp_t model(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (sel)
      4'h0: r = (ia + ib) % 256;
      4'h1: r = (ia - ib + 256) % 256;
      4'h2: r = (ia * ib) % 256;
      4'h3: r = (ib == 0) ? 255 : ia / ib;
      4'h4: r = (ia * 2) % 256;
      4'h5: r = ia / 2;
      4'h6: r = ((ia * 2) % 256) + (ia / 128);
      4'h7: r = (ia / 2) + ((ia % 2) * 128);
      4'h8: r = int'(a & b);
      4'h9: r = int'(a | b);
      4'hA: r = int'(a ^ b);
      4'hB: r = 255 - int'(a | b);
      4'hC: r = 255 - int'(a & b);
      4'hD: r = 255 - int'(a ^ b);
      4'hE: r = (ia > ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    e.res   = 8'(r);
    e.carry = (ia + ib) > 255;
    e.zero  = (r == 0);
    e.divz  = (sel == 4'h3) && (ib == 0);
    return e;
  endfunction

  // Drives one accepted op on the falling edge and queues its expected result.
  task automatic issue(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    @(negedge clk);
    A        = a;
    B        = b;
    ALU_Sel  = sel;
    in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    ALU_Sel  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ALU_Out !== 8'h00) begin errors++; $display("[TB] FAIL reset_out got=%h exp=00", ALU_Out); end
    checks++;
    if (CarryOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry got=%b exp=0", CarryOut); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (Zero !== 1'b0 || DivZero !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags got=%b%b exp=00", Zero, DivZero);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    last_exp = '{8'h00, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic test_ops;
    vec_t tbl[18];
    exp_t e, got;
    tbl = '{
      '{4'h9, 8'hA5, 8'h5A, 8'hFF, 1'b0},
      '{4'h0, 8'hFF, 8'h02, 8'h01, 1'b1},
      '{4'h2, 8'h10, 8'h11, 8'h10, 1'b0},
      '{4'h6, 8'h81, 8'h00, 8'h03, 1'b0},
      '{4'h7, 8'h81, 8'h00, 8'hC0, 1'b0},
      '{4'h5, 8'h81, 8'h00, 8'h40, 1'b0},
      '{4'h4, 8'h81, 8'h00, 8'h02, 1'b0},
      '{4'h3, 8'h64, 8'h00, 8'hFF, 1'b0},
      '{4'h3, 8'h64, 8'h07, 8'h0E, 1'b0},
      '{4'hE, 8'h05, 8'h03, 8'h01, 1'b0},
      '{4'hE, 8'h03, 8'h05, 8'h00, 1'b0},
      '{4'hF, 8'h3C, 8'h3C, 8'h01, 1'b0},
      '{4'h1, 8'h03, 8'h05, 8'hFE, 1'b0},
      '{4'h8, 8'hF0, 8'h3C, 8'h30, 1'b1},
      '{4'hA, 8'hF0, 8'h3C, 8'hCC, 1'b1},
      '{4'hB, 8'hF0, 8'h3C, 8'h03, 1'b1},
      '{4'hC, 8'hF0, 8'h3C, 8'hCF, 1'b1},
      '{4'hD, 8'hF0, 8'h3C, 8'h33, 1'b1}
    };
    foreach (tbl[i]) begin
      e.res   = tbl[i].res;
      e.carry = tbl[i].carry;
      e.zero  = (tbl[i].res == 8'h00);
      e.divz  = (tbl[i].sel == 4'h3) && (tbl[i].b == 8'h00);
      issue(tbl[i].sel, tbl[i].a, tbl[i].b, e);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("[TB] FAIL ops_valid[%0d] got=%b exp=1", i, out_valid);
        exp_q.delete();
      end else begin
        got = exp_q.pop_front();
        last_exp = got;
        checks++;
        if (ALU_Out !== got.res) begin
          errors++; $display("[TB] FAIL ops_out[%0d] sel=%h got=%h exp=%h", i, tbl[i].sel, ALU_Out, got.res);
        end
        checks++;
        if (CarryOut !== got.carry) begin
          errors++; $display("[TB] FAIL ops_carry[%0d] got=%b exp=%b", i, CarryOut, got.carry);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (Zero !== got.zero || DivZero !== got.divz) begin
          errors++; $display("[TB] FAIL ops_flags[%0d] got=%b%b exp=%b%b", i, Zero, DivZero, got.zero, got.divz);
        end
`endif
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_hold;
    @(negedge clk);
    A       = 8'h12;
    B       = 8'h34;
    ALU_Sel = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid[%0d] got=%b exp=0", c, out_valid); end
      checks++;
      if (ALU_Out !== last_exp.res || CarryOut !== last_exp.carry) begin
        errors++;
        $display("[TB] FAIL hold_out[%0d] got=%h/%b exp=%h/%b", c, ALU_Out, CarryOut, last_exp.res, last_exp.carry);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (Zero !== last_exp.zero || DivZero !== last_exp.divz) begin
        errors++; $display("[TB] FAIL hold_flags[%0d] got=%b%b exp=%b%b", c, Zero, DivZero, last_exp.zero, last_exp.divz);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] sel;
    logic [7:0] a, b;
    exp_t got;
    for (int n = 0; n < 40; n++) begin
      sel = 4'($urandom_range(0, 15));
      a   = 8'($urandom_range(0, 255));
      b   = (n % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      issue(sel, a, b, model(sel, a, b));
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("[TB] FAIL b2b_valid[%0d] got=%b exp=1", n, out_valid);
        exp_q.delete();
      end else begin
        got = exp_q.pop_front();
        last_exp = got;
        checks++;
        if (ALU_Out !== got.res || CarryOut !== got.carry) begin
          errors++;
          $display("[TB] FAIL b2b_out[%0d] sel=%h a=%h b=%h got=%h/%b exp=%h/%b",
                   n, sel, a, b, ALU_Out, CarryOut, got.res, got.carry);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (Zero !== got.zero || DivZero !== got.divz) begin
          errors++; $display("[TB] FAIL b2b_flags[%0d] got=%b%b exp=%b%b", n, Zero, DivZero, got.zero, got.divz);
        end
`endif
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_priority;
    exp_t got;
    issue(4'h0, 8'hFF, 8'h02, '{8'h01, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || ALU_Out !== got.res || CarryOut !== got.carry) begin
      errors++; $display("[TB] FAIL prio_setup got=%h/%b/%b exp=%h/%b/1", ALU_Out, CarryOut, out_valid, got.res, got.carry);
    end
    @(negedge clk);
    rst      = 1'b1;
    A        = 8'hA5;
    B        = 8'h5A;
    ALU_Sel  = 4'h9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_reset got=%h/%b/%b exp=00/0/0", ALU_Out, CarryOut, out_valid);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || ALU_Out !== 8'h00) begin
      errors++; $display("[TB] FAIL prio_dropped got=%h/%b exp=00/0", ALU_Out, out_valid);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    ALU_Sel  = '0;
    test_reset();
    test_ops();
    test_hold();
    test_back_to_back();
    test_hold();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
